// File: rtl/filter_window_xfade.sv
// Windowed filter-bank output stage: maps VGA coordinates into an upscaled image
// window and selects one filter channel. Define FILTER_XFADE_EN to crossfade between channels over 2^FADE_LOG2 frames.

`ifdef FILTER_XFADE_EN
module xfade_field #(
  parameter int W = 5,
  parameter int F = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [F-1:0] alpha,
  output logic [W-1:0] y
);
  localparam int PW = W + F + 2;
  logic [PW-1:0] wa;

  assign wa = (PW'(1) << F) - PW'(alpha);
  assign y  = W'((PW'(a) * wa + PW'(b) * PW'(alpha)) >> F);
endmodule
`endif

module filter_window_xfade #(
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120,
  parameter int WIN_X0      = 320,
  parameter int WIN_Y0      = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int N_FILT      = 8,
  parameter int FADE_LOG2   = 4,
  parameter int SEL_W       = $clog2(N_FILT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [SEL_W-1:0]      filter_sel,
  input  logic                  DE,
  input  logic [9:0]            x_pixel,
  input  logic [9:0]            y_pixel,
  input  logic [15:0]           rgb565_in,
  input  logic [16*N_FILT-1:0]  filt_rgb_in,
  output logic [9:0]            local_x,
  output logic [9:0]            local_y,
  output logic                  filter_en,
  output logic [15:0]           rgb565_out,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  fade_busy
);
  localparam int X_END  = WIN_X0 + (IMG_WIDTH << SCALE_SHIFT);
  localparam int Y_END  = WIN_Y0 + (IMG_HEIGHT << SCALE_SHIFT);
  localparam int IW     = (N_FILT > 1) ? $clog2(N_FILT) : 1;
  localparam int STAGES = 2;

  // ---------------- window mapping ----------------
  logic       in_win;
  logic [9:0] dx, dy;

  assign in_win = (int'(x_pixel) >= WIN_X0) && (int'(x_pixel) < X_END) &&
                  (int'(y_pixel) >= WIN_Y0) && (int'(y_pixel) < Y_END);
  assign dx        = x_pixel - 10'(WIN_X0);
  assign dy        = y_pixel - 10'(WIN_Y0);
  assign local_x   = in_win ? (dx >> SCALE_SHIFT) : '0;
  assign local_y   = in_win ? (dy >> SCALE_SHIFT) : '0;
  assign filter_en = in_win && DE;

  // ---------------- channel select ----------------
  logic [N_FILT-1:0][15:0] chans;
  logic [SEL_W-1:0]        sel_norm;

  always_comb begin
    chans    = filt_rgb_in;
    chans[0] = rgb565_in;  // channel 0 is the camera bypass
  end

  assign sel_norm = (int'(filter_sel) >= N_FILT) ? '0 : filter_sel;

  // ---------------- select FSM ----------------
`ifdef FILTER_XFADE_EN
  typedef enum logic [1:0] {IDLE, PENDING, FADE} state_t;
  localparam logic [FADE_LOG2-1:0] ALPHA_MAX = '1;
  logic [FADE_LOG2-1:0] alpha, alpha_n;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

  state_t           state, state_n;
  logic [SEL_W-1:0] nxt_sel, act_n, nxt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      active_sel <= '0;
      nxt_sel    <= '0;
`ifdef FILTER_XFADE_EN
      alpha      <= '0;
`endif
    end else begin
      state      <= state_n;
      active_sel <= act_n;
      nxt_sel    <= nxt_n;
`ifdef FILTER_XFADE_EN
      alpha      <= alpha_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    act_n   = active_sel;
    nxt_n   = nxt_sel;
`ifdef FILTER_XFADE_EN
    alpha_n = alpha;
`endif
    case (state)
      IDLE: begin
        // a frame_start in this same cycle only arms the change
        if (sel_norm != active_sel) begin
          nxt_n   = sel_norm;
          state_n = PENDING;
        end
      end
      PENDING: begin
        if (sel_norm == active_sel) begin
          state_n = IDLE;
        end else if (frame_start) begin
`ifdef FILTER_XFADE_EN
          alpha_n = FADE_LOG2'(1);
          state_n = FADE;
`else
          act_n   = nxt_sel;
          state_n = IDLE;
`endif
        end
      end
`ifdef FILTER_XFADE_EN
      FADE: begin
        // selection changes are ignored until the fade lands in IDLE
        if (frame_start) begin
          if (alpha == ALPHA_MAX) begin
            act_n   = nxt_sel;
            alpha_n = '0;
            state_n = IDLE;
          end else begin
            alpha_n = alpha + FADE_LOG2'(1);
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign fade_busy = (state != IDLE);

  // ---------------- pixel pipeline ----------------
  logic [STAGES:1] vld_pipe;
  logic [15:0]     old_px, old_q, rgb_q, px_s2;
  logic            win_q;

  assign old_px = chans[IW'(active_sel)];

`ifdef FILTER_XFADE_EN
  logic [15:0]          new_px, new_q, blend_px;
  logic [FADE_LOG2-1:0] alpha_q;

  assign new_px = (state == IDLE) ? old_px : chans[IW'(nxt_sel)];

  for (genvar f = 0; f < 3; f++) begin : g_fld
    localparam int LSB = (f == 0) ? 0 : (f == 1) ? 5 : 11;
    localparam int FW  = (f == 1) ? 6 : 5;
    xfade_field #(.W(FW), .F(FADE_LOG2)) u_fld (
      .a     (old_q[LSB +: FW]),
      .b     (new_q[LSB +: FW]),
      .alpha (alpha_q),
      .y     (blend_px[LSB +: FW])
    );
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      old_q    <= '0;
      rgb_q    <= '0;
      win_q    <= 1'b0;
`ifdef FILTER_XFADE_EN
      new_q    <= '0;
      alpha_q  <= '0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], DE};
      old_q    <= old_px;
      rgb_q    <= rgb565_in;
      win_q    <= in_win;
`ifdef FILTER_XFADE_EN
      new_q    <= new_px;
      alpha_q  <= alpha;
`endif
    end
  end

  always_comb begin
    px_s2 = '0;
    if (vld_pipe[1]) begin
`ifdef FILTER_XFADE_EN
      px_s2 = win_q ? blend_px : rgb_q;
`else
      px_s2 = win_q ? old_q : rgb_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb565_out <= '0;
    else        rgb565_out <= px_s2;
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_filter_window_xfade.sv
// Directed bench for filter_window_xfade with a scoreboard of expected output
// pixels; fade-specific steps follow FILTER_XFADE_EN.
module tb_filter_window_xfade;
  localparam int N  = 8;
  localparam int FL = 4;
  localparam int SW = 4;

  logic              clk = 1'b0, reset = 1'b1, frame_start = 1'b0, DE = 1'b0;
  logic [SW-1:0]     filter_sel = '0;
  logic [9:0]        x_pixel = '0, y_pixel = '0;
  logic [15:0]       rgb565_in = '0;
  logic [16*N-1:0]   filt_rgb_in = '0;
  logic [9:0]        local_x, local_y;
  logic              filter_en, out_valid, fade_busy;
  logic [15:0]       rgb565_out;
  logic [SW-1:0]     active_sel;

  always #5 clk = ~clk;

  filter_window_xfade #(.SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .filter_sel(filter_sel),
    .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel), .rgb565_in(rgb565_in),
    .filt_rgb_in(filt_rgb_in), .local_x(local_x), .local_y(local_y),
    .filter_en(filter_en), .rgb565_out(rgb565_out), .out_valid(out_valid),
    .active_sel(active_sel), .fade_busy(fade_busy)
  );

  typedef struct { logic [15:0] px; logic vld; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, cyc_cnt = 0;
  bit   chk_en = 1'b0;
  int   m_st = 0, m_act = 0, m_nxt = 0, m_alpha = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] chan(int s);
    return (s == 0) ? rgb565_in : filt_rgb_in[16*s +: 16];
  endfunction

  function automatic int fld(int o, int n, int a);
    return (o * ((1 << FL) - a) + n * a) >> FL;
  endfunction

  function automatic logic [15:0] blend(logic [15:0] o, logic [15:0] n, int a);
    int r, g, b;
    r = fld(int'(o[15:11]), int'(n[15:11]), a);
    g = fld(int'(o[10:5]),  int'(n[10:5]),  a);
    b = fld(int'(o[4:0]),   int'(n[4:0]),   a);
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  // One clock of stimulus: drive at negedge, queue the pixel expected two edges later,
  // then advance the reference select model across the coming posedge.
  task automatic drive(bit de, int x, int y, logic [15:0] rgb, bit fs, int sel);
    exp_t e;
    int   sn;
    bit   win;
    @(negedge clk);
    DE = de; x_pixel = 10'(x); y_pixel = 10'(y); rgb565_in = rgb;
    frame_start = fs; filter_sel = SW'(sel);
    win   = (x >= 320) && (x < 640) && (y >= 240) && (y < 480);
    e.vld = de;
    e.due = cyc_cnt + 2;
    if (!de)      e.px = 16'h0000;
    else if (!win) e.px = rgb;
    else          e.px = blend(chan(m_act), (m_st == 0) ? chan(m_act) : chan(m_nxt), m_alpha);
    sb.push_back(e);
    sn = (sel >= N) ? 0 : sel;
    case (m_st)
      0: if (sn != m_act) begin m_nxt = sn; m_st = 1; end
      1: begin
        if (sn == m_act) m_st = 0;
        else if (fs) begin
`ifdef FILTER_XFADE_EN
          m_alpha = 1; m_st = 2;
`else
          m_act = m_nxt; m_st = 0;
`endif
        end
      end
      default: begin
        if (fs) begin
          if (m_alpha == (1 << FL) - 1) begin m_act = m_nxt; m_alpha = 0; m_st = 0; end
          else m_alpha++;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b0;
    DE = 1'b0; frame_start = 1'b0; filter_sel = '0; x_pixel = '0; y_pixel = '0;
    #1;
    check("rst_rgb565_out", rgb565_out, 16'h0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_active_sel", active_sel, '0);
    check("rst_fade_busy", fade_busy, 1'b0);
    sb.delete();
    m_st = 0; m_act = 0; m_nxt = 0; m_alpha = 0;
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
  endtask

  // Output monitor: state every cycle, pixels as their scoreboard entries fall due
  always begin
    @(posedge clk);
    cyc_cnt++;
    #1;
    if (chk_en) begin
      check("active_sel", active_sel, m_act);
      check("fade_busy", fade_busy, m_st != 0);
      while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
        mon_e = sb.pop_front();
        check("rgb565_out", rgb565_out, mon_e.px);
        check("out_valid", out_valid, mon_e.vld);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) filt_rgb_in[16*i +: 16] = 16'(16'h0841 * i);
    filt_rgb_in[15:0]  = 16'hDEAD;
    filt_rgb_in[63:48] = 16'hFFFF;
    filt_rgb_in[95:80] = 16'h1234;
    #2;
    do_reset();

    // window edges and local coordinates
    drive(1, 319, 240, 16'h1111, 0, 0); #1 check("en_x319", filter_en, 1'b0);
    drive(1, 320, 240, 16'h2222, 0, 0); #1 check("en_x320", filter_en, 1'b1);
    check("lx_x320", local_x, 10'd0); check("ly_y240", local_y, 10'd0);
    drive(1, 639, 241, 16'h3333, 0, 0); #1 check("lx_x639", local_x, 10'd159);
    check("ly_y241", local_y, 10'd0);
    drive(1, 640, 300, 16'h4444, 0, 0); #1 check("en_x640", filter_en, 1'b0);
    check("lx_x640", local_x, 10'd0);
    drive(1, 400, 480, 16'h5555, 0, 0); #1 check("en_y480", filter_en, 1'b0);
    check("ly_y480", local_y, 10'd0);
    drive(1, 400, 479, 16'h6666, 0, 0); #1 check("lx_x400", local_x, 10'd40);
    check("ly_y479", local_y, 10'd119);
    drive(0, 400, 300, 16'h7777, 0, 0); #1 check("en_de0", filter_en, 1'b0);

    // bypass latency
    drive(1, 400, 300, 16'hF800, 0, 0);
    drive(0, 0, 0, 16'h0000, 0, 0);
    @(posedge clk); #2;
    check("bypass_f800", rgb565_out, 16'hF800);
    check("bypass_valid", out_valid, 1'b1);

    // out-of-range select behaves as bypass
    drive(1, 400, 300, 16'h07E0, 0, 9);
    drive(1, 400, 300, 16'h001F, 0, 9);
    drive(1, 100, 100, 16'hABCD, 0, 9);
    drive(0, 0, 0, 16'h0000, 0, 9);
    @(posedge clk); #2;
    check("sel9_outwin", rgb565_out, 16'hABCD);
    check("sel9_busy", fade_busy, 1'b0);

    // change to channel 3 mid-frame: held until a frame boundary
    drive(1, 400, 300, 16'h0000, 0, 3);
    drive(1, 400, 300, 16'h0000, 0, 3);
    drive(1, 400, 300, 16'h0000, 0, 3);
    @(posedge clk); #2;
    check("pend_active", active_sel, 4'd0);
    check("pend_busy", fade_busy, 1'b1);
`ifdef FILTER_XFADE_EN
    for (int p = 1; p <= 16; p++) begin
      drive(0, 0, 0, 16'h0000, 1, 3);
      drive(1, 400, 300, 16'h0000, 0, 3);
      if (p == 8) begin
        drive(0, 0, 0, 16'h0000, 0, 3);
        @(posedge clk); #2;
        check("blend_a8", rgb565_out, 16'h7BEF);
      end
    end
    @(posedge clk); #2;
    check("fade_done_active", active_sel, 4'd3);
    check("fade_done_busy", fade_busy, 1'b0);
`else
    drive(0, 0, 0, 16'h0000, 1, 3);
    @(posedge clk); #2;
    check("commit_active", active_sel, 4'd3);
    check("commit_busy", fade_busy, 1'b0);
`endif

    // 3 -> 5 -> 3 inside one pending frame
    drive(1, 400, 300, 16'h5555, 0, 5);
    drive(1, 400, 300, 16'h5555, 0, 5);
    drive(1, 400, 300, 16'h5555, 0, 3);
    drive(0, 0, 0, 16'h0000, 1, 3);
    drive(1, 400, 300, 16'h5555, 0, 3);
    @(posedge clk); #2;
    check("bounce_active", active_sel, 4'd3);
    check("bounce_busy", fade_busy, 1'b0);

    // reset in the middle of a select change
    drive(1, 400, 300, 16'h0F0F, 0, 5);
`ifdef FILTER_XFADE_EN
    repeat (7) begin
      drive(0, 0, 0, 16'h0000, 1, 5);
      drive(1, 400, 300, 16'h0F0F, 0, 5);
    end
`endif
    do_reset();
    drive(1, 400, 300, 16'h1357, 0, 0);
    drive(1, 400, 300, 16'h2468, 0, 0);
    drive(0, 0, 0, 16'h0000, 1, 0);
    @(posedge clk); #2;
    check("post_rst_busy", fade_busy, 1'b0);
    check("post_rst_active", active_sel, 4'd0);
`ifndef FILTER_XFADE_EN
    drive(1, 400, 300, 16'h0000, 0, 3);
    drive(0, 0, 0, 16'h0000, 1, 3);
    @(posedge clk); #2;
    check("rst_commit_active", active_sel, 4'd3);
`endif

    // drain the scoreboard with inputs that cannot move the FSM
    repeat (3) drive(0, 0, 0, 16'h0000, 0, m_act);
    repeat (2) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
